// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and request descriptor for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
  } req_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store lane placement, load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);
  logic [4:0]  sh;
  logic [31:0] shifted;

  assign sh = {addr_lo, 3'b000};

  always_comb begin
    be         = '0;
    lane_wdata = wdata << sh;
    shifted    = rdata >> sh;
    load_data  = shifted;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        load_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be        = 4'b0011 << addr_lo;
        load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        load_data  = rdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with a bounded wait on mem_ready.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking the address.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q, addr_eff;
  logic [31:0]       wdata_q, rdata_q;
  logic              err_q, rdy_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept, bad_req, timeout;
  logic [1:0]        al_lo, al_size;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_load;

  assign accept  = req_valid && req_ready;
  assign timeout = (cnt == CNT_W'(TIMEOUT));

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_req  = (req_size == SZ_X) || misaligned(req_size, req_addr[1:0]);
  assign addr_eff = req_addr;
`else
  assign bad_req = (req_size == SZ_X);
  always_comb begin
    addr_eff = req_addr;
    if (req_size == SZ_H)      addr_eff[0]   = 1'b0;
    else if (req_size == SZ_W) addr_eff[1:0] = 2'b00;
  end
`endif

  // One aligner: fed by the live request in IDLE (to register lane-shifted store data),
  // by the registered request afterwards (byte enables, load extraction).
  assign al_lo   = (state == IDLE) ? addr_eff[1:0] : addr_q[1:0];
  assign al_size = (state == IDLE) ? req_size : req_q.size;

  lsu_align u_align (
    .addr_lo    (al_lo),
    .size       (al_size),
    .uns        (req_q.uns),
    .wdata      (req_wdata),
    .rdata      (rdata_q),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_req ? RESP : ACCESS;
      ACCESS:  if (mem_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && rdy_q;
    mem_rd    = (state == ACCESS) && !req_q.we;
    mem_wr    = (state == ACCESS) && req_q.we;
    mem_be    = (state == ACCESS) ? al_be : 4'b0000;
    mem_addr  = (state == ACCESS) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata = (state == ACCESS) ? wdata_q : '0;
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && err_q;
    rsp_rdata = ((state == RESP) && !err_q && !req_q.we) ? al_load : '0;
  end

  // rdy_q holds req_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q   <= 1'b0;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        req_q   <= '{we: req_we, size: req_size, uns: req_unsigned};
        addr_q  <= addr_eff;
        wdata_q <= al_wdata;
        err_q   <= bad_req;
        cnt     <= '0;
      end else if (state == ACCESS) begin
        if (mem_ready) begin
          rdata_q <= mem_rdata;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (timeout) err_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 The module SHALL have parameter TIMEOUT, default 15, meaning maximum cycles to wait for mem_ready before an error response.
REQ-003 The module SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The module SHALL have port reset, input, 1, meaning reset, asynchronous, active-low.
REQ-005 The module SHALL have port req_valid / req_ready, input / output, 1 each, pipeline request handshake.
REQ-006 The module SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-007 The module SHALL have port req_size, input, 2, 0=byte, 1=half, 2=word; 3 is illegal.
REQ-008 The module SHALL have port req_unsigned, input, 1, zero-extend loads when set.
REQ-009 The module SHALL have ports req_addr (input, ADDR_W) and req_wdata (input, 32).
REQ-010 The module SHALL have ports rsp_valid (output, 1), rsp_rdata (output, 32) and rsp_err (output, 1) for the pipeline response.
REQ-011 The module SHALL have memory-side ports mem_addr (output, ADDR_W, word-aligned), mem_wdata (output, 32), mem_be (output, 4), mem_rd (output, 1), mem_wr (output, 1), mem_rdata (input, 32) and mem_ready (input, 1).

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-013 In IDLE, req_ready SHALL be 1; a request is accepted when req_valid && req_ready, and the FSM moves to ACCESS on the next edge.
REQ-014 On acceptance, the LSU SHALL register the address, size, sign mode, we and lane-shifted write data.
REQ-015 In ACCESS, mem_addr SHALL equal {addr[ADDR_W-1:2],2'b00}.
REQ-016 In ACCESS, mem_be SHALL be 4'b0001<<addr[1:0] for a byte access, 4'b0011<<addr[1:0] for a half access, and 4'b1111 for a word access.
REQ-017 In ACCESS, mem_wdata SHALL place the store data on the enabled lanes.
REQ-018 In ACCESS, mem_rd SHALL equal !we and mem_wr SHALL equal we; both SHALL be held stable until mem_ready.
REQ-019 When mem_ready is 1 in ACCESS, the LSU SHALL capture mem_rdata and go to RESP, so minimum request-to-rsp_valid latency is 2 cycles.
REQ-020 For a load, rsp_rdata SHALL be the selected lane(s) shifted to bit 0, sign- or zero-extended to 32 bits; for a store, rsp_rdata SHALL be 0.
REQ-021 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; back-to-back requests SHALL therefore be accepted every 3 cycles minimum.
REQ-022 A timeout counter SHALL clear on entry to ACCESS and increment each cycle that mem_ready is 0.
REQ-023 When the timeout counter reaches TIMEOUT, the LSU SHALL deassert mem_rd/mem_wr, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-024 A request with req_size=3 SHALL skip ACCESS and go directly to RESP with rsp_err=1.
REQ-025 A misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) SHALL be handled per REQ-031/REQ-032.
REQ-026 req_ready SHALL be 0 in ACCESS and RESP; req_valid in those states SHALL be ignored.
REQ-027 Outside ACCESS, mem_rd, mem_wr and mem_be SHALL be 0.

Reset
REQ-028 Assertion of reset (low) SHALL force IDLE immediately, regardless of the clock.
REQ-029 During reset, all outputs SHALL be 0 except req_ready, which SHALL be 0 while reset is low and 1 from the first edge after release.
REQ-030 Reset asserted during ACCESS SHALL abort the access with no response; mem_rd and mem_wr SHALL drop asynchronously.

Configuration
REQ-031 With LSU_MISALIGN_TRAP_EN defined, a misaligned request SHALL go to RESP with rsp_err=1 and no memory access.
REQ-032 Without LSU_MISALIGN_TRAP_EN, misaligned address bits SHALL be masked (half: addr[0] forced 0; word: addr[1:0] forced 0), the access SHALL proceed, and rsp_err SHALL be 0.

Structure
REQ-033 Package lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W), the FSM state enum and the default TIMEOUT constant.
REQ-034 Sub-module lsu_align SHALL be combinational and produce mem_be/mem_wdata lane placement and load extraction/extension; the FSM and counters SHALL be in load_store_unit.

Verification
REQ-035 Memory model preloaded with byte n = n; load word at 0x8 with mem_ready after 1 cycle -> rsp_rdata=0x0B0A0908, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-036 Memory word 0x000000F0 at 0x4; signed byte load at 0x4 -> rsp_rdata=0xFFFFFFF0; unsigned byte load at 0x4 -> rsp_rdata=0x000000F0.
REQ-037 Store half 0xBEEF at 0x6 -> mem_addr=0x4, mem_be=4'b1100, mem_wdata[31:16]=0xBEEF, mem_wr=1 until mem_ready.
REQ-038 mem_ready held 0 -> rsp_valid with rsp_err=1 after TIMEOUT+1 cycles in ACCESS, and mem_rd low from then on.
REQ-039 Word load at 0x5 -> with LSU_MISALIGN_TRAP_EN, rsp_err=1 and no mem_rd pulse; without it, mem_addr=0x4 and rsp_err=0.
REQ-040 Reset pulsed low mid-ACCESS -> mem_rd drops without a clock edge, no rsp_valid, and req_ready=1 on the first edge after release.
